// File: rtl/chunked_seq_adder_if.sv
// Operand/result handshake bundle for the chunked sequential adder.
interface chunked_seq_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/chunked_seq_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock, carry held
// in a register between cycles.
module chunked_seq_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic                clk,
   input logic                rst_n,
   chunked_seq_adder_if.slave bus
);
   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("WIDTH must be a multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t state;
   state_t state_n;

   logic [N-1:0][CHUNK-1:0] a_q;
   logic [N-1:0][CHUNK-1:0] b_q;
   logic [N-1:0][CHUNK-1:0] sum_q;
   logic [IW-1:0]           idx;
   logic                    carry_q;
   logic                    cout_q;
   logic                    ovf_q;
   logic [CHUNK-1:0]        a_c;
   logic [CHUNK-1:0]        b_c;
   logic [CHUNK:0]          res;
   logic                    last;
   logic                    accept;

   assign a_c    = a_q[idx];
   assign b_c    = b_q[idx];
   assign res    = {1'b0, a_c} + {1'b0, b_c}
                 + {{CHUNK{1'b0}}, carry_q};
   assign last   = (idx == IW'(N - 1));
   assign accept = (state == IDLE) && bus.in_valid;

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n       = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_n = BUSY;
         end
         BUSY: begin
            if (last) state_n = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Subtract is a + ~b + 1; the +1 rides in on the carry register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         a_q     <= bus.a;
         b_q     <= bus.sub ? ~bus.b : bus.b;
         carry_q <= bus.sub | bus.cin;
         idx     <= '0;
      end else if (state == BUSY) begin
         sum_q[idx] <= res[CHUNK-1:0];
         carry_q    <= res[CHUNK];
         idx        <= idx + IW'(1);
         if (last) begin
            cout_q <= res[CHUNK];
            ovf_q  <= (a_c[CHUNK-1] ~^ b_c[CHUNK-1])
                    & (res[CHUNK-1] ^ a_c[CHUNK-1]);
         end
      end
   end
endmodule

// File: tb/tb_chunked_seq_adder.sv
// Bench: directed vectors on the 16/4 unit, random scoreboard
// runs on 16/16, 16/1 and 32/8 instances.
module tb_chunked_seq_adder;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   chunked_seq_adder_if #(.WIDTH(16)) bus ();
   chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      res_t        exp;
      string       nm;
   } vec_t;

   res_t  sb[$];
   vec_t  vecs[10];
   bit    go = 1'b0;
   bit    done[3];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sub,
                               input logic [15:0] s, input logic co,
                               input logic ov, input string nm);
      vec_t v;
      v.a = a; v.b = b; v.cin = cin; v.sub = sub;
      v.exp.sum = s; v.exp.cout = co; v.exp.ovf = ov;
      v.nm = nm;
      return v;
   endfunction

   task automatic issue(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input res_t e);
      int g;
      g = 0;
      while (!bus.in_ready && g < 50) begin
         tick();
         g++;
      end
      bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      sb.push_back(e);
   endtask

   task automatic collect(input string nm, input int lat_exp);
      int   lat;
      res_t e;
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         tick();
         lat++;
      end
      chk({nm, "_lat"}, 64'(lat), 64'(lat_exp));
      if (sb.size() == 0) begin
         chk({nm, "_sb_empty"}, 64'(0), 64'(1));
      end else begin
         e = sb.pop_front();
         chk({nm, "_sum"}, 64'(bus.sum), 64'(e.sum));
         chk({nm, "_cout"}, 64'(bus.cout), 64'(e.cout));
         chk({nm, "_ovf"}, 64'(bus.ovf), 64'(e.ovf));
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({nm, "_ov_low"}, 64'(bus.out_valid), 64'(0));
      chk({nm, "_ir_high"}, 64'(bus.in_ready), 64'(1));
   endtask

   localparam int CW[3] = '{16, 16, 32};
   localparam int CC[3] = '{16, 1, 8};

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int W = CW[g];
      localparam int C = CC[g];

      typedef struct packed {
         logic [W-1:0] sum;
         logic         cout;
         logic         ovf;
      } rres_t;

      chunked_seq_adder_if #(.WIDTH(W)) rb ();
      chunked_seq_adder #(.WIDTH(W), .CHUNK(C)) rdut (
         .clk  (clk),
         .rst_n(rst_n),
         .bus  (rb.slave)
      );

      rres_t q[$];

      initial begin
         logic [W-1:0] ra;
         logic [W-1:0] rbv;
         logic         rc;
         logic         rs;
         logic [W:0]   full;
         rres_t        e;
         rres_t        x;
         int           lat;
         int           guard;
         bit           hs;
         rb.in_valid = 1'b0; rb.a = '0; rb.b = '0;
         rb.cin = 1'b0; rb.sub = 1'b0; rb.out_ready = 1'b0;
         done[g] = 1'b0;
         wait (go);
         tick();
         for (int i = 0; i < 1000; i++) begin
            ra  = W'($urandom);
            rbv = W'($urandom);
            rc  = 1'($urandom);
            rs  = 1'($urandom);
            if (rs) begin
               full   = {1'b0, ra} - {1'b0, rbv};
               e.cout = ~full[W];
               e.ovf  = (ra[W-1] != rbv[W-1]) && (full[W-1] != ra[W-1]);
            end else begin
               full   = {1'b0, ra} + {1'b0, rbv} + {{W{1'b0}}, rc};
               e.cout = full[W];
               e.ovf  = (ra[W-1] == rbv[W-1]) && (full[W-1] != ra[W-1]);
            end
            e.sum = full[W-1:0];
            repeat ($urandom_range(0, 2)) tick();
            guard = 0;
            while (!rb.in_ready && guard < 50) begin
               tick();
               guard++;
            end
            rb.a = ra; rb.b = rbv; rb.cin = rc; rb.sub = rs;
            rb.in_valid = 1'b1;
            tick();
            rb.in_valid = 1'b0;
            q.push_back(e);
            lat = 0;
            while (!rb.out_valid && lat < 100) begin
               tick();
               lat++;
            end
            chk($sformatf("cfg%0d_lat", g), 64'(lat), 64'(W / C));
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 100) begin
               rb.out_ready = 1'($urandom);
               if (rb.out_ready && rb.out_valid) begin
                  hs = 1'b1;
                  if (q.size() == 0) begin
                     chk($sformatf("cfg%0d_sb_empty", g), 64'(0), 64'(1));
                  end else begin
                     x = q.pop_front();
                     chk($sformatf("cfg%0d_op%0d_sum", g, i),
                         64'(rb.sum), 64'(x.sum));
                     chk($sformatf("cfg%0d_op%0d_cout", g, i),
                         64'(rb.cout), 64'(x.cout));
                     chk($sformatf("cfg%0d_op%0d_ovf", g, i),
                         64'(rb.ovf), 64'(x.ovf));
                  end
               end
               tick();
               guard++;
            end
            rb.out_ready = 1'b0;
            chk($sformatf("cfg%0d_hs", g), 64'(hs), 64'(1));
         end
         done[g] = 1'b1;
      end
   end

   initial begin
      res_t e;
      int   lat;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
      bus.cin = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_sum", 64'(bus.sum), 64'(0));
      chk("rst_cout", 64'(bus.cout), 64'(0));
      chk("rst_ovf", 64'(bus.ovf), 64'(0));
      rst_n = 1'b1;
      tick();

      vecs[0] = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ffff_1");
      vecs[1] = mk(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_5_7");
      vecs[2] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_8000_1");
      vecs[3] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_7fff_1");
      vecs[4] = mk(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "add_cin");
      vecs[5] = mk(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_0_0");
      vecs[6] = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "add_neg_ovf");
      vecs[7] = mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "add_ff_ff_c");
      vecs[8] = mk(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, "sub_7fff_m1");
      vecs[9] = mk(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "add_ripple");

      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp);
         collect(vecs[i].nm, 4);
      end

      // Backpressure: result must hold while the consumer stalls.
      e.sum = 16'h7FFF; e.cout = 1'b1; e.ovf = 1'b1;
      issue(16'h8000, 16'h0001, 1'b0, 1'b1, e);
      void'(sb.pop_front());
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         tick();
         lat++;
      end
      chk("bp_lat", 64'(lat), 64'(4));
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp%0d_ov", k), 64'(bus.out_valid), 64'(1));
         chk($sformatf("bp%0d_ir", k), 64'(bus.in_ready), 64'(0));
         chk($sformatf("bp%0d_sum", k), 64'(bus.sum), 64'(e.sum));
         chk($sformatf("bp%0d_cout", k), 64'(bus.cout), 64'(e.cout));
         chk($sformatf("bp%0d_ovf", k), 64'(bus.ovf), 64'(e.ovf));
         if (k == 1) begin
            bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0;
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         tick();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("bp_rel_ov", 64'(bus.out_valid), 64'(0));
      chk("bp_rel_ir", 64'(bus.in_ready), 64'(1));
      repeat (6) tick();
      chk("bp_no_ghost", 64'(bus.out_valid), 64'(0));

      // Asynchronous reset during the second BUSY cycle.
      e.sum = 16'hFFFF; e.cout = 1'b0; e.ovf = 1'b0;
      issue(16'hAAAA, 16'h5555, 1'b0, 1'b0, e);
      tick();
      chk("mid_busy_ir", 64'(bus.in_ready), 64'(0));
      rst_n = 1'b0;
      #1;
      chk("arst_ov", 64'(bus.out_valid), 64'(0));
      chk("arst_ir", 64'(bus.in_ready), 64'(1));
      chk("arst_sum", 64'(bus.sum), 64'(0));
      sb.delete();
      #2;
      rst_n = 1'b1;
      e.sum = 16'h0007; e.cout = 1'b0; e.ovf = 1'b0;
      issue(16'h0003, 16'h0004, 1'b0, 1'b0, e);
      collect("after_rst", 4);

      go = 1'b1;
      for (int t = 0; t < 90000; t++) begin
         if (done[0] && done[1] && done[2]) break;
         @(posedge clk);
      end
      chk("rand_done", 64'({done[0], done[1], done[2]}), 64'(3'b111));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
